// File: rtl/hazard_unit.sv
// Pipeline hazard unit for a five-stage in-order core.
// Resolves operand forwarding into Execute, load-use interlocks,
// branch/jump flushes and data-memory wait stalls, and keeps saturating
// counters of stalled and flushed cycles.
module hazard_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
    input  logic [REG_ADDR_WIDTH-1:0] RdE,
    input  logic [REG_ADDR_WIDTH-1:0] RdM,
    input  logic [REG_ADDR_WIDTH-1:0] RdW,
    input  logic                      RegWriteM,
    input  logic                      RegWriteW,
    input  logic                      LoadE,
    input  logic                      PCSrcE,
    input  logic                      MemReqM,
    input  logic                      MemReadyM,
    output logic [1:0]                ForwardAE,
    output logic [1:0]                ForwardBE,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      StallM,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic                      MemWait,
    output logic [CNT_WIDTH-1:0]      StallCount,
    output logic [CNT_WIDTH-1:0]      FlushCount
);

    localparam logic RUN     = 1'b0;
    localparam logic MEMWAIT = 1'b1;

    logic                 state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic mem_stall;
    logic stall_f_raw, stall_d_raw, stall_e_raw, stall_m_raw;
    logic flush_d_raw, flush_e_raw;
    logic stall_event;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    // Memory stage wins over Writeback; x0 is hard-wired zero and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic [REG_ADDR_WIDTH-1:0] rd_m,
        input logic                      we_m,
        input logic [REG_ADDR_WIDTH-1:0] rd_w,
        input logic                      we_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (we_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign load_use  = LoadE & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D));
    assign mem_stall = MemReqM & ~MemReadyM;

    // Zero-latency operand select for both Execute source operands.
    always_comb begin
        fwd_a_raw = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        fwd_b_raw = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end

    // Stall/flush priority: memory wait > taken branch > load-use.
    always_comb begin
        stall_f_raw = 1'b0;
        stall_d_raw = 1'b0;
        stall_e_raw = 1'b0;
        stall_m_raw = 1'b0;
        flush_d_raw = 1'b0;
        flush_e_raw = 1'b0;
        if (mem_stall) begin
            stall_f_raw = 1'b1;
            stall_d_raw = 1'b1;
            stall_e_raw = 1'b1;
            stall_m_raw = 1'b1;
        end else if (PCSrcE) begin
            // The wrong-path load-use pair is squashed, so no interlock is needed.
            flush_d_raw = 1'b1;
            flush_e_raw = 1'b1;
        end else if (load_use) begin
            stall_f_raw = 1'b1;
            stall_d_raw = 1'b1;
            flush_e_raw = 1'b1;
        end
    end

    // A load-use hidden behind a taken branch is discarded and not counted.
    assign stall_event = mem_stall | (load_use & ~PCSrcE);

    // Next-state for the memory-wait FSM and the saturating counters.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (mem_stall) state_d = MEMWAIT;
            MEMWAIT: if (MemReadyM) state_d = RUN;
            default: state_d = RUN;
        endcase
        stall_cnt_d = stall_cnt_q;
        if (stall_event && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        flush_cnt_d = flush_cnt_q;
        if (flush_e_raw && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // State and counters clear immediately on reset, even mid-wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Combinational outputs are held quiet while reset is asserted.
    always_comb begin
        ForwardAE = rst_n ? fwd_a_raw : 2'b00;
        ForwardBE = rst_n ? fwd_b_raw : 2'b00;
        StallF    = rst_n & stall_f_raw;
        StallD    = rst_n & stall_d_raw;
        StallE    = rst_n & stall_e_raw;
        StallM    = rst_n & stall_m_raw;
        FlushD    = rst_n & flush_d_raw;
        FlushE    = rst_n & flush_e_raw;
    end

    assign MemWait    = (state_q == MEMWAIT);
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit using an expectation queue.
module tb_hazard_unit;

    localparam int AW = 5;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, MemWait;
    logic [CW-1:0] StallCount, FlushCount;

    hazard_unit #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LoadE(LoadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .MemWait(MemWait),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty: observed %0h, no expectation queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
            $display("[TB] %s observed %0h expected %0h", e.tag, obs, e.val);
        end
    endtask

    task automatic clear_inputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
    endtask

    initial begin
        // Reset with hostile inputs: every output must stay quiet.
        clear_inputs();
        rst_n = 1'b0;
        RdM = 5; Rs1E = 5; RegWriteM = 1; LoadE = 1; RdE = 7; Rs2D = 7;
        MemReqM = 1; PCSrcE = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        push("rst_fwdA", 0);       chk(32'(ForwardAE));
        push("rst_stallF", 0);     chk(32'(StallF));
        push("rst_flushE", 0);     chk(32'(FlushE));
        push("rst_memwait", 0);    chk(32'(MemWait));
        push("rst_stallcnt", 0);   chk(32'(StallCount));
        push("rst_flushcnt", 0);   chk(32'(FlushCount));
        clear_inputs();
        rst_n = 1'b1;

        // Forward priority on operand A, then a mixed pattern on A/B.
        @(negedge clk);
        RdM = 5; RdW = 5; Rs1E = 5; Rs2E = 5; RegWriteM = 1; RegWriteW = 1; #1;
        push("fwdA_mem", 2);       chk(32'(ForwardAE));
        push("fwdB_mem", 2);       chk(32'(ForwardBE));
        RegWriteM = 0; #1;
        push("fwdA_wb", 1);        chk(32'(ForwardAE));
        RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0; RegWriteM = 1; #1;
        push("fwdA_x0", 0);        chk(32'(ForwardAE));
        push("fwdB_x0", 0);        chk(32'(ForwardBE));
        RdM = 3; Rs1E = 3; RdW = 4; Rs2E = 4; RegWriteM = 1; RegWriteW = 1; #1;
        push("fwdA_mix", 2);       chk(32'(ForwardAE));
        push("fwdB_mix", 1);       chk(32'(ForwardBE));
        clear_inputs();

        // Load into x0 is not a hazard.
        @(negedge clk);
        LoadE = 1; RdE = 0; Rs1D = 0; #1;
        push("lu_x0_stallF", 0);   chk(32'(StallF));
        clear_inputs();

        // Load-use interlock for one cycle.
        @(negedge clk);
        LoadE = 1; RdE = 7; Rs2D = 7; #1;
        push("lu_stallF", 1);      chk(32'(StallF));
        push("lu_stallD", 1);      chk(32'(StallD));
        push("lu_flushE", 1);      chk(32'(FlushE));
        push("lu_stallE", 0);      chk(32'(StallE));
        push("lu_flushD", 0);      chk(32'(FlushD));
        @(posedge clk);
        exp_stall++; exp_flush++;
        @(negedge clk);
        clear_inputs();
        push("lu_stallcnt", 32'(exp_stall)); chk(32'(StallCount));
        push("lu_flushcnt", 32'(exp_flush)); chk(32'(FlushCount));

        // Taken branch discards a simultaneous load-use.
        LoadE = 1; RdE = 7; Rs2D = 7; PCSrcE = 1; #1;
        push("br_flushD", 1);      chk(32'(FlushD));
        push("br_flushE", 1);      chk(32'(FlushE));
        push("br_stallF", 0);      chk(32'(StallF));
        push("br_stallD", 0);      chk(32'(StallD));
        @(posedge clk);
        exp_flush++;
        @(negedge clk);
        clear_inputs();
        push("br_stallcnt", 32'(exp_stall)); chk(32'(StallCount));
        push("br_flushcnt", 32'(exp_flush)); chk(32'(FlushCount));

        // Memory wait: three not-ready cycles with a branch pending, then ready.
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        for (int k = 1; k <= 3; k++) begin
            #1;
            push($sformatf("mw%0d_stallF", k), 1);  chk(32'(StallF));
            push($sformatf("mw%0d_stallM", k), 1);  chk(32'(StallM));
            push($sformatf("mw%0d_flushE", k), 0);  chk(32'(FlushE));
            push($sformatf("mw%0d_memwait", k), (k == 1) ? 0 : 1); chk(32'(MemWait));
            @(posedge clk);
            exp_stall++;
            @(negedge clk);
        end
        PCSrcE = 0; MemReadyM = 1; #1;
        push("mw4_memwait", 1);    chk(32'(MemWait));
        push("mw4_stallF", 0);     chk(32'(StallF));
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        push("mw_done_memwait", 0);          chk(32'(MemWait));
        push("mw_stallcnt", 32'(exp_stall)); chk(32'(StallCount));
        push("mw_flushcnt", 32'(exp_flush)); chk(32'(FlushCount));

        // Asynchronous reset while waiting on memory.
        MemReqM = 1; MemReadyM = 0;
        @(posedge clk);
        @(negedge clk);
        push("rw_memwait_pre", 1); chk(32'(MemWait));
        #2 rst_n = 1'b0;
        #1;
        push("rw_memwait", 0);     chk(32'(MemWait));
        push("rw_stallF", 0);      chk(32'(StallF));
        push("rw_stallcnt", 0);    chk(32'(StallCount));
        push("rw_flushcnt", 0);    chk(32'(FlushCount));
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;

        // Saturation: 2^CW+3 load-use cycles.
        @(negedge clk);
        LoadE = 1; RdE = 9; Rs1D = 9;
        repeat (254) @(posedge clk);
        #1;
        push("sat_pre_stallcnt", 254); chk(32'(StallCount));
        repeat ((1 << CW) + 3 - 254) @(posedge clk);
        @(negedge clk);
        clear_inputs();
        push("sat_stallcnt", 32'((1 << CW) - 1)); chk(32'(StallCount));
        push("sat_flushcnt", 32'((1 << CW) - 1)); chk(32'(FlushCount));
        @(posedge clk);
        @(negedge clk);
        push("sat_hold_stallcnt", 32'((1 << CW) - 1)); chk(32'(StallCount));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_WIDTH, default 5: register-file address width.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the performance counters.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: Rs1D, Rs2D  input  REG_ADDR_WIDTH  source registers in Decode.
REQ-007 Port: Rs1E, Rs2E, RdE  input  REG_ADDR_WIDTH  source and destination registers in Execute.
REQ-008 Port: RdM, RdW  input  REG_ADDR_WIDTH  destination registers in Memory and Writeback.
REQ-009 Port: RegWriteM, RegWriteW  input  1  register-write enables in Memory and Writeback.
REQ-010 Port: LoadE  input  1  Execute instruction is a load.
REQ-011 Port: PCSrcE  input  1  taken branch or jump resolved in Execute.
REQ-012 Port: MemReqM, MemReadyM  input  1  data-memory request and ready handshake in Memory.
REQ-013 Port: ForwardAE, ForwardBE  output  2  operand-select code: 00 register file (rdE), 01 ResultW, 10 ALUResultM; 11 is never driven.
REQ-014 Port: StallF, StallD, StallE, StallM  output  1  hold the PC and the IF/ID, ID/EX and EX/MEM registers.
REQ-015 Port: FlushD, FlushE  output  1  clear IF/ID and ID/EX to a bubble.
REQ-016 Port: MemWait  output  1  FSM is in MEMWAIT.
REQ-017 Port: StallCount, FlushCount  output  CNT_WIDTH  saturating performance counters.

Function
REQ-018 ForwardAE SHALL be 10 when RegWriteM=1, RdM!=0 and RdM==Rs1E.
REQ-019 Otherwise, ForwardAE SHALL be 01 when RegWriteW=1, RdW!=0 and RdW==Rs1E.
REQ-020 Otherwise, ForwardAE SHALL be 00.
REQ-021 ForwardBE SHALL follow REQ-018 to REQ-020 using Rs2E.
REQ-022 Forwarding SHALL be combinational, with zero latency.
REQ-023 The Memory stage SHALL take priority over Writeback.
REQ-024 Register x0 SHALL never be forwarded.
REQ-025 The block SHALL compute a combinational signal loadUse = LoadE & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D).
REQ-026 The FSM SHALL have two states, RUN and MEMWAIT.
REQ-027 In RUN, the FSM SHALL go to MEMWAIT when MemReqM=1 and MemReadyM=0.
REQ-028 In MEMWAIT, the FSM SHALL go to RUN on the clock edge at which MemReadyM=1.
REQ-029 The block SHALL compute a combinational signal memStall = MemReqM & ~MemReadyM, evaluated in either state.
REQ-030 When memStall=1, StallF, StallD, StallE and StallM SHALL be 1 and FlushD and FlushE SHALL be 0, overriding every other rule.
REQ-031 When memStall=0 and PCSrcE=1, FlushD and FlushE SHALL be 1 and all stall outputs SHALL be 0; a simultaneous loadUse is discarded.
REQ-032 When memStall=0, PCSrcE=0 and loadUse=1, StallF, StallD and FlushE SHALL be 1, and StallE, StallM and FlushD SHALL be 0.
REQ-033 When none of memStall, PCSrcE or loadUse is 1, all stall and flush outputs SHALL be 0.
REQ-034 StallCount SHALL increment by 1 each clock in which memStall=1 or loadUse=1 is applied.
REQ-035 FlushCount SHALL increment by 1 each clock in which FlushE=1.
REQ-036 Both counters SHALL saturate at all-ones and never wrap.
REQ-037 MemWait SHALL be registered and equal to (state==MEMWAIT).

Reset
REQ-038 While rst_n=0, the state SHALL be RUN and both counters SHALL be 0.
REQ-039 While rst_n=0, MemWait, all stall and flush outputs, ForwardAE and ForwardBE SHALL all be 0, regardless of inputs.
REQ-040 Assertion of rst_n=0 in MEMWAIT SHALL return the FSM to RUN immediately, without waiting for a clock edge.
REQ-041 After rst_n is released, the next rising edge SHALL be the first active cycle.

Verification
REQ-042 Forward priority: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 -> ForwardAE=10; then RegWriteM=0 -> ForwardAE=01; then RdM=RdW=Rs1E=0 -> ForwardAE=00.
REQ-043 Load-use: LoadE=1, RdE=7, Rs2D=7 for one cycle -> StallF=StallD=FlushE=1 for that cycle; StallCount 0 -> 1.
REQ-044 Branch over load-use: PCSrcE=1 together with the REQ-043 stimulus -> FlushD=FlushE=1, StallF=0, FlushCount=1, StallCount unchanged.
REQ-045 Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then MemReadyM=1 -> StallF/D/E/M=1 for 3 cycles, MemWait=1 from the 2nd to the 4th cycle, StallCount=3; a simultaneous PCSrcE=1 gives FlushE=0 throughout.
REQ-046 Reset mid-wait: rst_n=0 asynchronously while in MEMWAIT -> MemWait, StallF and both counters read 0 before the next edge.
REQ-047 Saturation: 2^CNT_WIDTH+3 load-use cycles -> StallCount holds at all-ones.
